rf_write_arbiter: RTL and testbench

Shares the single regfile write port between the processor and N hardware event sources: the control button, down/bounce/slow flags, the collision flag and the level flag.
- The processor path passes through combinationally and always wins, because the processor cannot stall.
- Hardware requests are buffered one-deep per source and drained round-robin in cycles where the processor is not writing.
- Sits between the processor/hardware sources and the regfile, replacing the ad-hoc direct flag inputs to the regfile.

---
 rtl/rf_write_arbiter.sv | 112 +++++++++++
 tb/tb_rf_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port: processor passes through combinationally, hw sources buffered one-deep and drained round-robin.
// Latency: processor 0 cycles; hw request commits no earlier than the cycle after it is presented.
// Backpressure: none upstream; processor always wins, a re-request on an occupied slot replaces it and bumps drop_count.
module rf_write_arbiter #(
    parameter int N        = 4,
    parameter int MAX_WAIT = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            proc_we,
    input  logic [4:0]      proc_reg,
    input  logic [31:0]     proc_data,
    input  logic [N-1:0]    hw_req,
    input  logic [5*N-1:0]  hw_reg,
    input  logic [32*N-1:0] hw_data,
    output logic [N-1:0]    hw_grant,
    output logic [N-1:0]    hw_pending,
    output logic            rf_we,
    output logic [4:0]      rf_reg,
    output logic [31:0]     rf_data,
    output logic [7:0]      drop_count,
    output logic            starve
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [N-1:0]       slot_vld;
    logic [N-1:0][4:0]  slot_reg;
    logic [N-1:0][31:0] slot_dat;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      sel;
    logic [PW-1:0]      idx;
    logic               found;
    logic               drain;
    logic [WW-1:0]      wait_cnt;
    logic [WW-1:0]      wait_nxt;
    logic [7:0]         drop_nxt;
    int                 drop_sum;

    // First valid slot at or after rr_ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N);
            if (!found && slot_vld[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign drain      = !reset && !proc_we && found;
    assign hw_pending = slot_vld;

    always_comb begin
        hw_grant = '0;
        rf_we    = 1'b0;
        rf_reg   = '0;
        rf_data  = '0;
        if (reset || proc_we) begin
            rf_we   = proc_we;
            rf_reg  = proc_reg;
            rf_data = proc_data;
        end else if (drain) begin
            hw_grant[sel] = 1'b1;
            rf_reg        = slot_reg[sel];
            rf_data       = slot_dat[sel];
            rf_we         = (slot_reg[sel] != 5'd0);
        end
    end

    always_comb begin
        drop_sum = int'(drop_count) + $countones(hw_req & slot_vld & ~hw_grant);
        drop_nxt = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
        wait_nxt = wait_cnt;
        if ((|hw_grant) || !(|slot_vld))
            wait_nxt = '0;
        else if (wait_cnt < WAIT_MAX)
            wait_nxt = wait_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_vld   <= '0;
            slot_reg   <= '0;
            slot_dat   <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
            wait_cnt   <= '0;
            starve     <= 1'b0;
        end else begin
            // A request in the grant cycle refills the slot rather than clearing it.
            for (int i = 0; i < N; i++) begin
                if (hw_req[i]) begin
                    slot_vld[i] <= 1'b1;
                    slot_reg[i] <= hw_reg[5*i +: 5];
                    slot_dat[i] <= hw_data[32*i +: 32];
                end else if (hw_grant[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
            if (drain)
                rr_ptr <= PW'((int'(sel) + 1) % N);
            drop_count <= drop_nxt;
            wait_cnt   <= wait_nxt;
            starve     <= (wait_nxt >= WAIT_MAX);
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a slot/queue reference model.
module tb_rf_write_arbiter;
    localparam int N    = 4;
    localparam int MAXW = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            proc_we;
    logic [4:0]      proc_reg;
    logic [31:0]     proc_data;
    logic [N-1:0]    hw_req;
    logic [5*N-1:0]  hw_reg;
    logic [32*N-1:0] hw_data;
    logic [N-1:0]    hw_grant;
    logic [N-1:0]    hw_pending;
    logic            rf_we;
    logic [4:0]      rf_reg;
    logic [31:0]     rf_data;
    logic [7:0]      drop_count;
    logic            starve;

    rf_write_arbiter #(.N(N), .MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .proc_we(proc_we), .proc_reg(proc_reg), .proc_data(proc_data),
        .hw_req(hw_req), .hw_reg(hw_reg), .hw_data(hw_data),
        .hw_grant(hw_grant), .hw_pending(hw_pending),
        .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
        .drop_count(drop_count), .starve(starve)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_vld [N];
    logic [4:0]  m_reg [N];
    logic [31:0] m_dat [N];
    int          m_rr, m_drop, m_wait;

    // outputs observed in the most recent step
    logic            obs_we;
    logic [4:0]      obs_reg;
    logic [31:0]     obs_data;
    logic [N-1:0]    obs_grant, obs_pend;
    logic [7:0]      obs_drop;
    logic            obs_starve;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_reg[i] = '0;
            m_dat[i] = '0;
        end
        m_rr = 0; m_drop = 0; m_wait = 0;
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks the immediate effect.
    task automatic do_reset();
        reset = 1'b1; proc_we = 1'b1; proc_reg = 5'd9; proc_data = 32'h0000_0abc;
        hw_req = '0; hw_reg = '0; hw_data = '0;
        #1;
        check_val("rst_pending", 32'(hw_pending), 32'd0);
        check_val("rst_drop",    32'(drop_count), 32'd0);
        check_val("rst_starve",  32'(starve),     32'd0);
        check_val("rst_grant",   32'(hw_grant),   32'd0);
        check_val("rst_rf_we",   32'(rf_we),      32'd1);
        check_val("rst_rf_reg",  32'(rf_reg),     32'd9);
        check_val("rst_rf_data", rf_data,         32'h0000_0abc);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; proc_we = 1'b0; proc_reg = '0; proc_data = '0;
    endtask

    // One clock cycle: drive, check against model, clock, update model.
    task automatic step(input logic pwe, input logic [4:0] preg, input logic [31:0] pdata,
                        input logic [N-1:0] req, input logic [5*N-1:0] regs,
                        input logic [32*N-1:0] datas);
        logic            e_we;
        logic [4:0]      e_reg;
        logic [31:0]     e_data;
        logic [N-1:0]    e_grant, e_pend;
        int              gi;
        bit              anyv;
        proc_we = pwe; proc_reg = preg; proc_data = pdata;
        hw_req = req; hw_reg = regs; hw_data = datas;
        #2;
        e_we = 1'b0; e_reg = '0; e_data = '0; e_grant = '0; e_pend = '0; gi = -1; anyv = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_pend[i] = m_vld[i];
            if (m_vld[i]) anyv = 1'b1;
        end
        if (pwe) begin
            e_we = 1'b1; e_reg = preg; e_data = pdata;
        end else begin
            for (int k = 0; k < N; k++)
                if (gi < 0 && m_vld[(m_rr + k) % N]) gi = (m_rr + k) % N;
            if (gi >= 0) begin
                e_grant[gi] = 1'b1;
                e_reg  = m_reg[gi];
                e_data = m_dat[gi];
                e_we   = (m_reg[gi] != 5'd0);
            end
        end
        obs_we = rf_we; obs_reg = rf_reg; obs_data = rf_data; obs_grant = hw_grant;
        obs_pend = hw_pending; obs_drop = drop_count; obs_starve = starve;
        check_val("rf_we",      32'(rf_we),      32'(e_we));
        check_val("rf_reg",     32'(rf_reg),     32'(e_reg));
        check_val("rf_data",    rf_data,         e_data);
        check_val("hw_grant",   32'(hw_grant),   32'(e_grant));
        check_val("hw_pending", 32'(hw_pending), 32'(e_pend));
        check_val("drop_count", 32'(drop_count), 32'(m_drop));
        check_val("starve",     32'(starve),     32'(m_wait >= MAXW));
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (m_vld[i] && gi != i) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                m_vld[i] = 1'b1;
                m_reg[i] = regs[5*i +: 5];
                m_dat[i] = datas[32*i +: 32];
            end else if (gi == i) begin
                m_vld[i] = 1'b0;
            end
        end
        if (gi >= 0) m_rr = (gi + 1) % N;
        if (gi >= 0 || !anyv) m_wait = 0;
        else if (m_wait < MAXW) m_wait = m_wait + 1;
        @(negedge clock);
    endtask

    task automatic idle(input logic pwe);
        step(pwe, 5'd0, 32'd0, '0, '0, '0);
    endtask

    task automatic req_one(input int src, input logic [4:0] r, input logic [31:0] d, input logic pwe);
        logic [N-1:0]    q;
        logic [5*N-1:0]  rv;
        logic [32*N-1:0] dv;
        q = '0; rv = '0; dv = '0;
        q[src] = 1'b1;
        rv[5*src +: 5] = r;
        dv[32*src +: 32] = d;
        step(pwe, 5'd0, 32'd0, q, rv, dv);
    endtask

    task automatic req_all();
        logic [5*N-1:0]  rv;
        logic [32*N-1:0] dv;
        for (int i = 0; i < N; i++) begin
            rv[5*i +: 5]   = 5'(21 + i);
            dv[32*i +: 32] = 32'(100 + i);
        end
        step(1'b0, 5'd0, 32'd0, '1, rv, dv);
    endtask

    initial begin
        logic [N-1:0]    q;
        logic [5*N-1:0]  rv;
        logic [32*N-1:0] dv;
        int              order [4];

        do_reset();

        // processor passthrough
        step(1'b1, 5'd5, 32'h0000_0123, '0, '0, '0);
        check_val("pt_we", 32'(obs_we), 32'd1);
        check_val("pt_reg", 32'(obs_reg), 32'd5);
        check_val("pt_data", obs_data, 32'h0000_0123);
        check_val("pt_grant", 32'(obs_grant), 32'd0);

        // deferred drain
        do_reset();
        req_one(0, 5'd21, 32'd1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step(1'b1, 5'd3, 32'(c), '0, '0, '0);
            check_val("defer_pend", 32'(obs_pend[0]), 32'd1);
        end
        idle(1'b0);
        check_val("defer_pend4", 32'(obs_pend[0]), 32'd1);
        check_val("defer_grant", 32'(obs_grant), 32'b0001);
        check_val("defer_reg", 32'(obs_reg), 32'd21);
        check_val("defer_data", obs_data, 32'd1);
        check_val("defer_we", 32'(obs_we), 32'd1);
        idle(1'b0);
        check_val("defer_clear", 32'(obs_pend[0]), 32'd0);

        // round robin from rr_ptr=0, then from rr_ptr=2
        do_reset();
        req_all();
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            check_val("rr0_grant", 32'(obs_grant), 32'(1 << k));
            check_val("rr0_reg", 32'(obs_reg), 32'(21 + k));
        end
        req_one(1, 5'd2, 32'd5, 1'b0);
        idle(1'b0);
        req_all();
        order = '{2, 3, 0, 1};
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            check_val("rr2_grant", 32'(obs_grant), 32'(1 << order[k]));
        end

        // overwrite and saturation
        do_reset();
        req_one(1, 5'd24, 32'd7, 1'b1);
        req_one(1, 5'd24, 32'd9, 1'b1);
        idle(1'b0);
        check_val("ovw_data", obs_data, 32'd9);
        check_val("ovw_drop", 32'(obs_drop), 32'd1);
        for (int k = 0; k < 300; k++) req_one(1, 5'd24, 32'(k), 1'b1);
        idle(1'b0);
        check_val("sat_drop", 32'(obs_drop), 32'd255);

        // register 0 target, then grant colliding with a fresh request
        do_reset();
        req_one(2, 5'd0, 32'hdead_beef, 1'b0);
        idle(1'b0);
        check_val("r0_grant", 32'(obs_grant), 32'b0100);
        check_val("r0_we", 32'(obs_we), 32'd0);
        idle(1'b0);
        check_val("r0_clear", 32'(obs_pend), 32'd0);
        req_one(2, 5'd3, 32'h0000_00aa, 1'b0);
        req_one(2, 5'd4, 32'h0000_00bb, 1'b0);
        check_val("col_grant", 32'(obs_grant), 32'b0100);
        idle(1'b0);
        check_val("col_pend", 32'(obs_pend[2]), 32'd1);
        check_val("col_data", obs_data, 32'h0000_00bb);
        check_val("col_drop", 32'(obs_drop), 32'd0);

        // starvation, then reset while starving with a drop recorded
        do_reset();
        req_one(0, 5'd6, 32'd66, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            idle(1'b1);
            check_val("starve_c", 32'(obs_starve), 32'(c >= 9));
        end
        idle(1'b0);
        check_val("starve_g", 32'(obs_grant), 32'b0001);
        idle(1'b0);
        check_val("starve_off", 32'(obs_starve), 32'd0);
        req_one(3, 5'd7, 32'd1, 1'b1);
        req_one(3, 5'd7, 32'd2, 1'b1);
        for (int c = 0; c < 10; c++) idle(1'b1);
        check_val("pre_rst_starve", 32'(obs_starve), 32'd1);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if (c % 500 == 499) do_reset();
            for (int i = 0; i < N; i++) begin
                q[i] = ($urandom_range(0, 3) == 0);
                rv[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                dv[32*i +: 32] = $urandom;
            end
            step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), $urandom, q, rv, dv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
